// File: rtl/debounce_edge_gen.sv
// -----------------------------------------------------------------------------
// debounce_edge_gen
//
// Conditions a raw, asynchronous, bouncing switch or button signal for the
// D flip-flop stages downstream. The raw input goes through a synchronizer
// chain and is then debounced. A new level is accepted only after it has been
// seen for STABLE_CNT consecutive synchronized samples. The block delivers a
// clean level plus one-cycle rise and fall pulses.
//
// All outputs are registered on posedge clk, except busy. busy is a decode of
// the state register, so it is also free of input glitches. A consumer that
// samples on negedge therefore sees stable values.
//
// Parameters
//   SYNC_STAGES  number of synchronizer flops on din_raw (2..4)
//   STABLE_CNT   consecutive samples of the new value needed to accept it
//                (2..2**CNT_W-1)
//   CNT_W        stability counter width
//
// Ports
//   clk      clock, all state updates on its rising edge
//   rst      synchronous, active-high reset
//   din_raw  raw asynchronous switch input
//   dout     debounced level
//   rise     one-cycle pulse when dout goes 0->1
//   fall     one-cycle pulse when dout goes 1->0
//   busy     high while a candidate transition is being qualified
//   state_o  current FSM state
// -----------------------------------------------------------------------------
module debounce_edge_gen #(
   parameter int SYNC_STAGES = 2,
   parameter int STABLE_CNT  = 4,
   parameter int CNT_W       = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       din_raw,
   output logic       dout,
   output logic       rise,
   output logic       fall,
   output logic       busy,
   output logic [1:0] state_o
);

   typedef enum logic [1:0] {
      IDLE_LOW  = 2'b00,
      CHK_HIGH  = 2'b01,
      IDLE_HIGH = 2'b11,
      CHK_LOW   = 2'b10
   } state_t;

   // Counter value on the edge that completes a qualification.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CNT - 1);

   // ------------------------------------------------------------------
   // Synchronizer chain. Only its last stage is visible to the FSM.
   // ------------------------------------------------------------------
   logic [SYNC_STAGES-1:0] sync_reg;
   logic [SYNC_STAGES-1:0] sync_next;
   logic                   s;

   assign sync_next[0] = din_raw;

   genvar gi;
   generate
      for (gi = 1; gi < SYNC_STAGES; gi++) begin : g_sync
         assign sync_next[gi] = sync_reg[gi-1];
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_reg <= '0;
      end else begin
         sync_reg <= sync_next;
      end
   end

   assign s = sync_reg[SYNC_STAGES-1];

   // ------------------------------------------------------------------
   // Debounce FSM
   // ------------------------------------------------------------------
   state_t           state_reg, state_next;
   logic [CNT_W-1:0] cnt_reg,   cnt_next;
   logic             dout_reg,  dout_next;
   logic             rise_reg,  rise_next;
   logic             fall_reg,  fall_next;

   // State register. The registered outputs live here as well.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE_LOW;
         cnt_reg   <= '0;
         dout_reg  <= 1'b0;
         rise_reg  <= 1'b0;
         fall_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         dout_reg  <= dout_next;
         rise_reg  <= rise_next;
         fall_reg  <= fall_next;
      end
   end

   // Next-state and counter logic. The counter only runs in the CHK states.
   // It leaves those states on the edge where it equals CNT_LAST, so it can
   // neither exceed that value nor wrap.
   always_comb begin
      state_next = state_reg;
      cnt_next   = '0;
      unique case (state_reg)
         IDLE_LOW: begin
            if (s) begin
               state_next = CHK_HIGH;
               cnt_next   = CNT_W'(1);
            end
         end
         CHK_HIGH: begin
            if (!s) begin
               state_next = IDLE_LOW;
            end else if (cnt_reg == CNT_LAST) begin
               state_next = IDLE_HIGH;
            end else begin
               cnt_next = cnt_reg + CNT_W'(1);
            end
         end
         IDLE_HIGH: begin
            if (!s) begin
               state_next = CHK_LOW;
               cnt_next   = CNT_W'(1);
            end
         end
         CHK_LOW: begin
            if (s) begin
               state_next = IDLE_HIGH;
            end else if (cnt_reg == CNT_LAST) begin
               state_next = IDLE_LOW;
            end else begin
               cnt_next = cnt_reg + CNT_W'(1);
            end
         end
         default: begin
            state_next = IDLE_LOW;
         end
      endcase
   end

   // Output logic. The pulses default low and are raised only on the edge
   // that completes a qualification, so each pulse lasts exactly one cycle.
   // Rise and fall come from different states, so they are never high together.
   always_comb begin
      dout_next = dout_reg;
      rise_next = 1'b0;
      fall_next = 1'b0;
      unique case (state_reg)
         CHK_HIGH: begin
            if (s && cnt_reg == CNT_LAST) begin
               dout_next = 1'b1;
               rise_next = 1'b1;
            end
         end
         CHK_LOW: begin
            if (!s && cnt_reg == CNT_LAST) begin
               dout_next = 1'b0;
               fall_next = 1'b1;
            end
         end
         default: begin
         end
      endcase
   end

   assign busy    = (state_reg == CHK_HIGH) || (state_reg == CHK_LOW);
   assign dout    = dout_reg;
   assign rise    = rise_reg;
   assign fall    = fall_reg;
   assign state_o = state_reg;

endmodule

// File: tb/tb_debounce_edge_gen.sv
// -----------------------------------------------------------------------------
// tb_debounce_edge_gen
//
// Directed bench for debounce_edge_gen. Two instances share clk and rst:
//   dut_a  default parameters (SYNC_STAGES=2, STABLE_CNT=4)
//   dut_b  SYNC_STAGES=3, STABLE_CNT=2
//
// Each step drives din, waits for one posedge and samples the outputs 1 time
// unit later. The step's own edge is the edge where sync[0] captures the
// driven value. Each sampled vector is packed as {state, dout, rise, fall, busy}.
// -----------------------------------------------------------------------------
module tb_debounce_edge_gen;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       din_a = 1'b0;
   logic       din_b = 1'b0;
   logic       dout_a, rise_a, fall_a, busy_a;
   logic       dout_b, rise_b, fall_b, busy_b;
   logic [1:0] state_a, state_b;

   int n_vec = 0;
   int n_err = 0;
   int cyc   = 0;

   // Expected output vectors: {state[1:0], dout, rise, fall, busy}
   localparam logic [5:0] V_IL   = 6'b00_0_0_0_0;  // idle low
   localparam logic [5:0] V_CH   = 6'b01_0_0_0_1;  // checking high
   localparam logic [5:0] V_IH_R = 6'b11_1_1_0_0;  // idle high + rise pulse
   localparam logic [5:0] V_IH   = 6'b11_1_0_0_0;  // idle high
   localparam logic [5:0] V_CL   = 6'b10_1_0_0_1;  // checking low
   localparam logic [5:0] V_IL_F = 6'b00_0_0_1_0;  // idle low + fall pulse

   always #5 clk = ~clk;

   debounce_edge_gen #(
      .SYNC_STAGES(2),
      .STABLE_CNT (4),
      .CNT_W      (4)
   ) dut_a (
      .clk    (clk),
      .rst    (rst),
      .din_raw(din_a),
      .dout   (dout_a),
      .rise   (rise_a),
      .fall   (fall_a),
      .busy   (busy_a),
      .state_o(state_a)
   );

   debounce_edge_gen #(
      .SYNC_STAGES(3),
      .STABLE_CNT (2),
      .CNT_W      (4)
   ) dut_b (
      .clk    (clk),
      .rst    (rst),
      .din_raw(din_b),
      .dout   (dout_b),
      .rise   (rise_b),
      .fall   (fall_b),
      .busy   (busy_b),
      .state_o(state_b)
   );

   task automatic check_vec(input string tag, input logic [5:0] got, input logic [5:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s (cycle %0d): got {st,dout,rise,fall,busy}=%b, expected %b",
                  tag, cyc, got, exp);
      end
   endtask

   task automatic step_a(input string tag, input logic d, input logic [5:0] exp);
      din_a = d;
      @(posedge clk);
      #1;
      cyc++;
      check_vec(tag, {state_a, dout_a, rise_a, fall_a, busy_a}, exp);
      $display("a %-10s din=%b -> st=%b dout=%b rise=%b fall=%b busy=%b",
               tag, d, state_a, dout_a, rise_a, fall_a, busy_a);
   endtask

   task automatic step_b(input string tag, input logic d, input logic [5:0] exp);
      din_b = d;
      @(posedge clk);
      #1;
      cyc++;
      check_vec(tag, {state_b, dout_b, rise_b, fall_b, busy_b}, exp);
      $display("b %-10s din=%b -> st=%b dout=%b rise=%b fall=%b busy=%b",
               tag, d, state_b, dout_b, rise_b, fall_b, busy_b);
   endtask

   initial begin
      // Reset held 3 cycles with din high. Everything reads 0 during reset.
      rst = 1'b1;
      for (int i = 0; i < 3; i++) step_a("rst_hold", 1'b1, V_IL);

      // The first post-reset edge (e0) sees din=1 as a new transition.
      // rise is expected at e0+5.
      rst = 1'b0;
      step_a("rst_e0", 1'b1, V_IL);
      step_a("rst_e1", 1'b1, V_IL);
      step_a("rst_e2", 1'b1, V_CH);
      step_a("rst_e3", 1'b1, V_CH);
      step_a("rst_e4", 1'b1, V_CH);
      step_a("rst_e5", 1'b1, V_IH_R);
      step_a("rst_e6", 1'b1, V_IH);
      step_a("rst_e7", 1'b1, V_IH);

      // Clean fall from IDLE_HIGH. fall is expected at e0+5.
      step_a("fall_e0", 1'b0, V_IH);
      step_a("fall_e1", 1'b0, V_IH);
      step_a("fall_e2", 1'b0, V_CL);
      step_a("fall_e3", 1'b0, V_CL);
      step_a("fall_e4", 1'b0, V_CL);
      step_a("fall_e5", 1'b0, V_IL_F);
      step_a("fall_e6", 1'b0, V_IL);

      // Clean rise with defaults. busy is high from e0+2 to e0+4.
      step_a("rise_e0", 1'b1, V_IL);
      step_a("rise_e1", 1'b1, V_IL);
      step_a("rise_e2", 1'b1, V_CH);
      step_a("rise_e3", 1'b1, V_CH);
      step_a("rise_e4", 1'b1, V_CH);
      step_a("rise_e5", 1'b1, V_IH_R);
      step_a("rise_e6", 1'b1, V_IH);

      // Fall aborted by reset at e0+3. No fall pulse, back to IDLE_LOW.
      step_a("rfall_e0", 1'b0, V_IH);
      step_a("rfall_e1", 1'b0, V_IH);
      step_a("rfall_e2", 1'b0, V_CL);
      rst = 1'b1;
      step_a("rfall_e3", 1'b0, V_IL);
      rst = 1'b0;
      step_a("rfall_e4", 1'b0, V_IL);
      step_a("rfall_e5", 1'b0, V_IL);
      step_a("rfall_e6", 1'b0, V_IL);

      // Bounce rejection: 1,1,0,1,1,0 then 0. dout must never go high.
      step_a("bnc_0", 1'b1, V_IL);
      step_a("bnc_1", 1'b1, V_IL);
      step_a("bnc_2", 1'b0, V_CH);
      step_a("bnc_3", 1'b1, V_CH);
      step_a("bnc_4", 1'b1, V_IL);
      step_a("bnc_5", 1'b0, V_CH);
      step_a("bnc_6", 1'b0, V_CH);
      step_a("bnc_7", 1'b0, V_IL);
      step_a("bnc_8", 1'b0, V_IL);
      step_a("bnc_9", 1'b0, V_IL);

      // Bounce then settle: 1,0,1 then held high. The final 0->1 is captured
      // at edge 2, so rise is expected at edge 7.
      step_a("set_0", 1'b1, V_IL);
      step_a("set_1", 1'b0, V_IL);
      step_a("set_2", 1'b1, V_CH);
      step_a("set_3", 1'b1, V_IL);
      step_a("set_4", 1'b1, V_CH);
      step_a("set_5", 1'b1, V_CH);
      step_a("set_6", 1'b1, V_CH);
      step_a("set_7", 1'b1, V_IH_R);
      step_a("set_8", 1'b1, V_IH);
      step_a("set_9", 1'b1, V_IH);

      // Second instance: SYNC_STAGES=3, STABLE_CNT=2, giving a latency of 4.
      step_b("b_rise_e0", 1'b1, V_IL);
      step_b("b_rise_e1", 1'b1, V_IL);
      step_b("b_rise_e2", 1'b1, V_IL);
      step_b("b_rise_e3", 1'b1, V_CH);
      step_b("b_rise_e4", 1'b1, V_IH_R);
      step_b("b_rise_e5", 1'b1, V_IH);
      step_b("b_fall_e0", 1'b0, V_IH);
      step_b("b_fall_e1", 1'b0, V_IH);
      step_b("b_fall_e2", 1'b0, V_IH);
      step_b("b_fall_e3", 1'b0, V_CL);
      step_b("b_fall_e4", 1'b0, V_IL_F);
      step_b("b_fall_e5", 1'b0, V_IL);

      // A 1-cycle glitch is rejected.
      step_b("b_glt_0", 1'b1, V_IL);
      step_b("b_glt_1", 1'b0, V_IL);
      step_b("b_glt_2", 1'b0, V_IL);
      step_b("b_glt_3", 1'b0, V_CH);
      step_b("b_glt_4", 1'b0, V_IL);
      step_b("b_glt_5", 1'b0, V_IL);

      // A 2-cycle pulse is accepted, then the release is qualified.
      step_b("b_pls_0", 1'b1, V_IL);
      step_b("b_pls_1", 1'b1, V_IL);
      step_b("b_pls_2", 1'b0, V_IL);
      step_b("b_pls_3", 1'b0, V_CH);
      step_b("b_pls_4", 1'b0, V_IH_R);
      step_b("b_pls_5", 1'b0, V_CL);
      step_b("b_pls_6", 1'b0, V_IL_F);
      step_b("b_pls_7", 1'b0, V_IL);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
